// File: rtl/avr_reg_bank_pkg.sv
// Shared definitions for the AVR SPI register bank: register map addresses,
// CTRL/STATUS bit positions and small request-decode helpers. Imported by the
// RTL and by the bench so both use one copy of the map.
package avr_reg_bank_pkg;

    // Register map
    localparam logic [5:0] ADDR_ID          = 6'h00;
    localparam logic [5:0] ADDR_CTRL        = 6'h01;
    localparam logic [5:0] ADDR_STATUS      = 6'h02;
    localparam logic [5:0] ADDR_MASK        = 6'h03;
    localparam logic [5:0] ADDR_PERIOD_BASE = 6'h10;
    localparam logic [5:0] ADDR_FIFO_PEEK   = 6'h3E;
    localparam logic [5:0] ADDR_FIFO_POP    = 6'h3F;

    // CTRL bits
    localparam int CTRL_GEN_BIT    = 0;
    localparam int CTRL_CLR_BIT    = 1;

    // STATUS bits
    localparam int STATUS_OVF_BIT  = 7;
    localparam int STATUS_UDF_BIT  = 6;
    localparam int STATUS_FULL_BIT = 5;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_e;

    // Classify the upstream strobe/direction pair into one access kind.
    function automatic req_kind_e req_kind(input logic new_req, input logic write);
        if (!new_req)
            return REQ_IDLE;
        else if (write)
            return REQ_WRITE;
        else
            return REQ_READ;
    endfunction

    // Period registers occupy 0x10..0x1F (lo/hi pairs per drive).
    function automatic logic is_period_addr(input logic [5:0] addr);
        return (addr[5:4] == ADDR_PERIOD_BASE[5:4]);
    endfunction

endpackage

// File: rtl/avr_reg_bank_evt_fifo.sv
// Synchronous event FIFO. Head is always visible on dout; a pop is ignored
// when empty, a push is ignored when full unless a pop frees a slot in the
// same cycle. clear empties the FIFO and overrides any push/pop that cycle.
module evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/avr_reg_bank.sv
// Register bank behind the AVR SPI register interface: device ID, control,
// sticky status, drive enable mask, per-drive step periods (lo shadow + hi
// commit) and an event FIFO the AVR drains by reading the pop address.
module avr_reg_bank
    import avr_reg_bank_pkg::*;
#(
    parameter int          NUM_DRIVES = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  DEVICE_ID  = 8'hF1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5:0]                reg_addr,
    input  logic                      write,
    input  logic                      new_req,
    input  logic [7:0]                write_value,
    output logic [7:0]                read_value,
    input  logic                      evt_valid,
    input  logic [7:0]                evt_data,
    output logic                      evt_ready,
    output logic [NUM_DRIVES-1:0]     drive_enable,
    output logic [16*NUM_DRIVES-1:0]  drive_period,
    output logic [NUM_DRIVES-1:0]     period_update
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Control state
    logic                  r_gen;
    logic [NUM_DRIVES-1:0] r_mask;
    logic [NUM_DRIVES-1:0] r_drive_en;
    logic                  r_ovf;
    logic                  r_udf;
    logic [7:0]            r_read;

    // Period state
    logic [7:0]            r_shadow_lo [NUM_DRIVES];
    logic [15:0]           r_period    [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] r_update;

    // Decode
    req_kind_e             w_kind;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_per_sel;
    logic [2:0]            w_per_idx;
    logic                  w_per_hi;

    // FIFO interface
    logic [7:0]            w_fifo_dout;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop_req;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_clear;

    // Flag and control next-state
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic                  w_ovf_clr;
    logic                  w_udf_clr;
    logic                  w_gen_nxt;
    logic [NUM_DRIVES-1:0] w_mask_nxt;
    logic [7:0]            w_status;
    logic [7:0]            w_rd_data;

    assign w_kind    = req_kind(new_req, write);
    assign w_rd      = (w_kind == REQ_READ);
    assign w_wr      = (w_kind == REQ_WRITE);
    assign w_per_idx = reg_addr[3:1];
    assign w_per_hi  = reg_addr[0];
    assign w_per_sel = is_period_addr(reg_addr) && (32'(w_per_idx) < NUM_DRIVES);

    // A pop only happens on an explicit read of the pop address with data present.
    assign w_pop_req = w_rd && (reg_addr == ADDR_FIFO_POP);
    assign w_pop     = w_pop_req && !w_fifo_empty;
    assign w_udf_set = w_pop_req && w_fifo_empty;

    // A full FIFO still accepts a byte when the same cycle pops one, so the
    // count holds steady; otherwise an offered byte while full is dropped.
    assign w_push    = evt_valid && (!w_fifo_full || w_pop);
    assign w_ovf_set = evt_valid && w_fifo_full && !w_pop;
    assign evt_ready = !w_fifo_full;

    assign w_clear   = w_wr && (reg_addr == ADDR_CTRL) && write_value[CTRL_CLR_BIT];
    assign w_ovf_clr = w_wr && (reg_addr == ADDR_STATUS) && write_value[STATUS_OVF_BIT];
    assign w_udf_clr = w_wr && (reg_addr == ADDR_STATUS) && write_value[STATUS_UDF_BIT];

    assign w_gen_nxt  = (w_wr && reg_addr == ADDR_CTRL) ? write_value[CTRL_GEN_BIT] : r_gen;
    assign w_mask_nxt = (w_wr && reg_addr == ADDR_MASK) ? write_value[NUM_DRIVES-1:0] : r_mask;

    assign w_status = {r_ovf, r_udf, w_fifo_full, 5'(w_fifo_count)};

    evt_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (w_clear),
        .din   (evt_data),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Control, mask and sticky flags; drive enable is computed from the
    // next-state values so it tracks a write in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen      <= 1'b0;
            r_mask     <= '0;
            r_drive_en <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_gen      <= w_gen_nxt;
            r_mask     <= w_mask_nxt;
            r_drive_en <= w_mask_nxt & {NUM_DRIVES{w_gen_nxt}};
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_ovf_clr)
                r_ovf <= 1'b0;
            if (w_udf_set)
                r_udf <= 1'b1;
            else if (w_udf_clr)
                r_udf <= 1'b0;
        end
    end

    // Period shadows and commits; the hi-byte write commits the full word and
    // raises a one-cycle update pulse for that drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                r_shadow_lo[i] <= '0;
                r_period[i]    <= '0;
            end
            r_update <= '0;
        end else begin
            r_update <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (w_wr && w_per_sel && (w_per_idx == 3'(i))) begin
                    if (w_per_hi) begin
                        r_period[i] <= {write_value, r_shadow_lo[i]};
                        r_update[i] <= 1'b1;
                    end else begin
                        r_shadow_lo[i] <= write_value;
                    end
                end
            end
        end
    end

    // Read data mux; unmapped addresses read zero.
    always_comb begin
        w_rd_data = 8'h00;
        case (reg_addr)
            ADDR_ID:        w_rd_data = DEVICE_ID;
            ADDR_CTRL:      w_rd_data = {7'b0, r_gen};
            ADDR_STATUS:    w_rd_data = w_status;
            ADDR_MASK:      w_rd_data = 8'(r_mask);
            ADDR_FIFO_PEEK,
            ADDR_FIFO_POP:  w_rd_data = w_fifo_empty ? 8'h00 : w_fifo_dout;
            default: begin
                for (int i = 0; i < NUM_DRIVES; i++) begin
                    if (w_per_sel && (w_per_idx == 3'(i)))
                        w_rd_data = w_per_hi ? r_period[i][15:8] : r_shadow_lo[i];
                end
            end
        endcase
    end

    // Registered read data, held until the next read request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_read <= 8'h00;
        else if (w_rd)
            r_read <= w_rd_data;
    end

    assign read_value    = r_read;
    assign drive_enable  = r_drive_en;
    assign period_update = r_update;

    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_period_out
        assign drive_period[16*g +: 16] = r_period[g];
    end

endmodule

// File: tb/tb_avr_reg_bank.sv
// Self-checking bench for avr_reg_bank: reset values, period shadow/commit,
// enable masking, FIFO fill/drain/overflow/underflow, W1C, clear, async reset.
module tb_avr_reg_bank;
    import avr_reg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  reg_addr;
    logic        write;
    logic        new_req;
    logic [7:0]  write_value;
    logic [7:0]  read_value;
    logic        evt_valid;
    logic [7:0]  evt_data;
    logic        evt_ready;
    logic [3:0]  drive_enable;
    logic [63:0] drive_period;
    logic [3:0]  period_update;

    avr_reg_bank #(
        .NUM_DRIVES (4),
        .FIFO_DEPTH (16),
        .DEVICE_ID  (8'hF1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_addr      (reg_addr),
        .write         (write),
        .new_req       (new_req),
        .write_value   (write_value),
        .read_value    (read_value),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ready     (evt_ready),
        .drive_enable  (drive_enable),
        .drive_period  (drive_period),
        .period_update (period_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        string      name;
        logic [5:0] addr;
        logic       wr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge; reads push their expectation and are
    // scored at the next negedge when read_value has been registered.
    task automatic access(input logic [5:0] a, input logic w, input logic [7:0] d,
                          input logic [7:0] e, input string name);
        sb_t s;
        reg_addr    = a;
        write       = w;
        write_value = d;
        new_req     = 1'b1;
        if (!w) begin
            s.name = name;
            s.exp  = e;
            sb_q.push_back(s);
        end
        @(negedge clk);
        if (!w) begin
            s = sb_q.pop_front();
            chk(s.name, 64'(read_value), 64'(s.exp));
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        access(a, 1'b1, d, 8'h00, "write");
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string name);
        access(a, 1'b0, 8'h00, e, name);
    endtask

    task automatic idle();
        new_req = 1'b0;
        write   = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_evt(input logic [7:0] d);
        evt_valid = 1'b1;
        evt_data  = d;
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg_addr    = '0;
        write       = 1'b0;
        new_req     = 1'b0;
        write_value = '0;
        evt_valid   = 1'b0;
        evt_data    = '0;

        // Reset values while reset is held
        #12;
        chk("rst_read_value",    64'(read_value),    64'h00);
        chk("rst_evt_ready",     64'(evt_ready),     64'h1);
        chk("rst_drive_enable",  64'(drive_enable),  64'h0);
        chk("rst_drive_period",  drive_period,       64'h0);
        chk("rst_period_update", 64'(period_update), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        rd(ADDR_ID,     8'hF1, "read_id");
        rd(ADDR_STATUS, 8'h00, "read_status_reset");

        // Period lo goes to the shadow only; hi commits and pulses
        wr(6'h10, 8'h34);
        chk("period_before_hi", drive_period, 64'h0);
        chk("update_before_hi", 64'(period_update), 64'h0);
        wr(6'h11, 8'h12);
        chk("period_after_hi", drive_period, 64'h0000_0000_0000_1234);
        chk("update_pulse",    64'(period_update), 64'h1);
        idle();
        chk("update_cleared",  64'(period_update), 64'h0);

        // Table of register accesses
        vecs[0]  = '{"rd_lo0",        6'h10, 1'b0, 8'h00, 8'h34};
        vecs[1]  = '{"rd_hi0",        6'h11, 1'b0, 8'h00, 8'h12};
        vecs[2]  = '{"rd_lo1",        6'h12, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{"wr_hi1",        6'h13, 1'b1, 8'h56, 8'h00};
        vecs[4]  = '{"rd_hi1",        6'h13, 1'b0, 8'h00, 8'h56};
        vecs[5]  = '{"wr_drive4",     6'h18, 1'b1, 8'h77, 8'h00};
        vecs[6]  = '{"rd_drive4",     6'h18, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{"wr_unmapped",   6'h04, 1'b1, 8'h55, 8'h00};
        vecs[8]  = '{"rd_unmapped",   6'h04, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{"rd_unmapped20", 6'h20, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{"wr_id",         6'h00, 1'b1, 8'hAA, 8'h00};
        vecs[11] = '{"rd_id_again",   6'h00, 1'b0, 8'h00, 8'hF1};
        vecs[12] = '{"wr_peek",       6'h3E, 1'b1, 8'h11, 8'h00};
        vecs[13] = '{"rd_peek_empty", 6'h3E, 1'b0, 8'h00, 8'h00};
        vecs[14] = '{"rd_unmapped1f", 6'h1F, 1'b0, 8'h00, 8'h00};
        vecs[15] = '{"rd_ctrl_reset", 6'h01, 1'b0, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++)
            access(vecs[i].addr, vecs[i].wr, vecs[i].data, vecs[i].exp, vecs[i].name);
        chk("period_table", drive_period, 64'h0000_0000_5600_1234);

        // Enable masking
        wr(ADDR_MASK, 8'hFF);
        chk("enable_mask_only", 64'(drive_enable), 64'h0);
        wr(ADDR_CTRL, 8'h01);
        chk("enable_on", 64'(drive_enable), 64'hF);
        rd(ADDR_MASK, 8'h0F, "read_mask");
        wr(ADDR_CTRL, 8'h00);
        chk("enable_off", 64'(drive_enable), 64'h0);
        rd(ADDR_MASK, 8'h0F, "mask_retained");
        idle();

        // Fill past full
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("ready_before_push%0d", k), 64'(evt_ready), 64'(k < 16));
            push_evt(8'(8'hA0 + k));
        end
        chk("ready_full", 64'(evt_ready), 64'h0);
        rd(ADDR_STATUS, 8'hB0, "status_full_ovf");
        for (int k = 0; k < 16; k++)
            rd(ADDR_FIFO_POP, 8'(8'hA0 + k), $sformatf("pop%0d", k));
        rd(ADDR_FIFO_POP, 8'h00, "pop_empty");
        rd(ADDR_STATUS, 8'hC0, "status_udf");
        idle();

        // Full FIFO with simultaneous push and pop
        for (int k = 0; k < 16; k++)
            push_evt(8'(8'hC0 + k));
        evt_valid = 1'b1;
        evt_data  = 8'h5A;
        rd(ADDR_FIFO_POP, 8'hC0, "pop_while_full");
        evt_valid = 1'b0;
        rd(ADDR_STATUS, 8'hF0, "status_pushpop_full");
        wr(ADDR_STATUS, 8'hC0);
        rd(ADDR_STATUS, 8'h30, "status_w1c");
        evt_valid = 1'b1;
        evt_data  = 8'h77;
        wr(ADDR_STATUS, 8'h80);
        evt_valid = 1'b0;
        rd(ADDR_STATUS, 8'hB0, "set_beats_w1c");
        wr(ADDR_STATUS, 8'h80);
        rd(ADDR_STATUS, 8'h30, "status_w1c_again");
        rd(ADDR_FIFO_PEEK, 8'hC1, "peek_head");
        rd(ADDR_FIFO_PEEK, 8'hC1, "peek_no_pop");
        wr(ADDR_CTRL, 8'h02);
        chk("ready_after_clear", 64'(evt_ready), 64'h1);
        rd(ADDR_STATUS, 8'h00, "status_after_clear");
        rd(ADDR_CTRL, 8'h00, "ctrl_clear_reads0");
        rd(ADDR_FIFO_PEEK, 8'h00, "peek_after_clear");

        // Async reset between lo and hi writes
        wr(6'h10, 8'h34);
        wr(6'h11, 8'h12);
        wr(ADDR_MASK, 8'h0F);
        wr(ADDR_CTRL, 8'h01);
        push_evt(8'h42);
        rd(ADDR_ID, 8'hF1, "read_id_pre_reset");
        wr(6'h10, 8'h99);
        new_req = 1'b0;
        write   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_read_value",    64'(read_value),    64'h00);
        chk("arst_drive_enable",  64'(drive_enable),  64'h0);
        chk("arst_drive_period",  drive_period,       64'h0);
        chk("arst_evt_ready",     64'(evt_ready),     64'h1);
        chk("arst_period_update", 64'(period_update), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wr(6'h11, 8'hAB);
        chk("period_after_reset", drive_period, 64'h0000_0000_0000_AB00);
        rd(6'h10, 8'h00, "shadow_after_reset");
        rd(ADDR_STATUS, 8'h00, "status_after_reset");
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
